// File: rtl/buf_bus_arbiter.sv
// Round-robin arbiter that grants one requester at a time onto a buffered shared bus,
// registering the owner's data and forcing an OE-low turnaround between owners.
module buf_bus_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned MAXHOLD = 8,
    parameter int unsigned TURN    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    input  logic [N*W-1:0]       DIN,
    output logic [N-1:0]         GNT,
    output logic                 OE,
    output logic [W-1:0]         Z,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 BUSY
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned SW = OW + 1;
    localparam int unsigned HW = $clog2(MAXHOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_TURN
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            oe_q, oe_d;
    logic [W-1:0]    z_q, z_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            busy_q, busy_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [1:0]      turn_q, turn_d;
    logic [OW-1:0]   start_q, start_d;

    logic [W-1:0]    din_a [N];
    logic [OW-1:0]   win_idx;
    logic            win_found;
    logic            req_own;
    logic            req_other;
    logic            hold_sat;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            din_a[i] = DIN[i*W +: W];
        end
    end

    // First set request searching upward from start_q, wrapping at N.
    always_comb begin : pick
        logic [SW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, start_q} + SW'(i);
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (!win_found && REQ[cand[OW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OW-1:0];
            end
        end
    end

    assign req_own   = |(REQ & gnt_q);
    assign req_other = |(REQ & ~gnt_q);
    assign hold_sat  = (hold_q == HW'(MAXHOLD));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        oe_d    = oe_q;
        z_d     = '0;
        owner_d = owner_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        start_d = start_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (win_found) begin
                    state_d = ST_DRIVE;
                    gnt_d   = N'(1) << win_idx;
                    oe_d    = 1'b1;
                    owner_d = win_idx;
                    z_d     = din_a[win_idx];
                    hold_d  = HW'(1);
                    busy_d  = 1'b1;
                    start_d = (win_idx == OW'(N - 1)) ? '0 : win_idx + OW'(1);
                end
            end
            ST_DRIVE: begin
                if (!req_own || (hold_sat && req_other)) begin
                    state_d = ST_TURN;
                    gnt_d   = '0;
                    oe_d    = 1'b0;
                    turn_d  = 2'd1;
                    busy_d  = 1'b1;
                end else begin
                    z_d    = din_a[owner_q];
                    hold_d = hold_sat ? hold_q : hold_q + HW'(1);
                end
            end
            ST_TURN: begin
                gnt_d = '0;
                oe_d  = 1'b0;
                if (turn_q == 2'(TURN)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    turn_d = turn_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            oe_q    <= 1'b0;
            z_q     <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            oe_q    <= oe_d;
            z_q     <= z_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            start_q <= start_d;
        end
    end

    assign GNT   = gnt_q;
    assign OE    = oe_q;
    assign Z     = z_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_buf_bus_arbiter.sv
// Directed bench for buf_bus_arbiter: a TURN=1 instance for most scenarios and a
// TURN=3 instance for the pulse/turnaround case, plus per-cycle contention invariants.
module tb_buf_bus_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam logic [31:0] DIN_BASE = 32'hD3C2B1A0;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  din;

    logic [3:0]   gnt, gnt3;
    logic         oe, oe3;
    logic [7:0]   z, z3;
    logic [1:0]   owner, owner3;
    logic         busy, busy3;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    buf_bus_arbiter #(.N(N), .W(W), .MAXHOLD(8), .TURN(1)) u_dut (
        .CLK(clk), .RST(rst), .REQ(req), .DIN(din),
        .GNT(gnt), .OE(oe), .Z(z), .OWNER(owner), .BUSY(busy)
    );

    buf_bus_arbiter #(.N(N), .W(W), .MAXHOLD(8), .TURN(3)) u_dut3 (
        .CLK(clk), .RST(rst), .REQ(req), .DIN(din),
        .GNT(gnt3), .OE(oe3), .Z(z3), .OWNER(owner3), .BUSY(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slice(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    // Contention invariants on both instances, sampled just after each edge.
    logic       prev_oe = 1'b0, prev_oe3 = 1'b0;
    logic [1:0] prev_own = '0, prev_own3 = '0;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("inv_onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("inv_oe_or", 32'(oe), 32'(|gnt));
            check("inv_z_off", 32'(!oe && (z != 8'h00)), 32'd0);
            check("inv_own_chg", 32'(prev_oe && oe && (owner != prev_own)), 32'd0);
            check("inv3_onehot", 32'($countones(gnt3) <= 1), 32'd1);
            check("inv3_oe_or", 32'(oe3), 32'(|gnt3));
            check("inv3_z_off", 32'(!oe3 && (z3 != 8'h00)), 32'd0);
            check("inv3_own_chg", 32'(prev_oe3 && oe3 && (owner3 != prev_own3)), 32'd0);
        end
        prev_oe   = oe;
        prev_own  = owner;
        prev_oe3  = oe3;
        prev_own3 = owner3;
    end

    initial begin
        int olow;
        rst = 1'b1;
        req = '0;
        din = DIN_BASE;

        // Reset state
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_oe", 32'(oe), 32'h0);
        check("rst_z", 32'(z), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        // Single requester 1 for five cycles, Z trailing DIN slice 1
        req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            din[15:8] = 8'h10 + 8'(c);
            tick();
            check("single_gnt", 32'(gnt), 32'h2);
            check("single_oe", 32'(oe), 32'h1);
            check("single_z", 32'(z), 32'h10 + 32'(c));
        end
        req = '0;
        tick();
        check("single_turn_oe", 32'(oe), 32'h0);
        check("single_turn_z", 32'(z), 32'h0);
        check("single_turn_busy", 32'(busy), 32'h1);
        check("single_turn_owner", 32'(owner), 32'h1);
        tick();
        check("single_idle_oe", 32'(oe), 32'h0);
        check("single_idle_busy", 32'(busy), 32'h0);

        // Asynchronous reset while requester 2 drives
        din = DIN_BASE;
        req = 4'b0100;
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'h4);
        check("pre_rst_z", 32'(z), 32'hC2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_oe", 32'(oe), 32'h0);
        check("async_rst_z", 32'(z), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        #1 rst = 1'b0;
        req = 4'b1111;
        tick();

        // Round robin under continuous full request: 8-cycle grants, 2-cycle gaps
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                check("rr_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
                check("rr_owner", 32'(owner), 32'(g % 4));
                check("rr_z", 32'(z), 32'(slice(DIN_BASE, g % 4)));
                tick();
            end
            check("rr_gap1_oe", 32'(oe), 32'h0);
            check("rr_gap1_gnt", 32'(gnt), 32'h0);
            if (g == 4) req = '0;
            tick();
            check("rr_gap2_oe", 32'(oe), 32'h0);
            check("rr_gap2_busy", 32'(busy), 32'h0);
            tick();
        end
        check("rr_end_gnt", 32'(gnt), 32'h0);

        // Preemption: requester 1 saturates, requester 3 arrives on the 12th edge
        req = 4'b0010;
        tick();
        for (int c = 0; c < 11; c++) begin
            check("pre_hold_gnt", 32'(gnt), 32'h2);
            if (c == 10) req = 4'b1010;
            tick();
        end
        check("pre_exit_oe", 32'(oe), 32'h0);
        check("pre_exit_gnt", 32'(gnt), 32'h0);
        tick();
        check("pre_idle_oe", 32'(oe), 32'h0);
        tick();
        check("pre_new_gnt", 32'(gnt), 32'h8);
        check("pre_new_owner", 32'(owner), 32'h3);
        check("pre_new_z", 32'(z), 32'hD3);
        req = '0;
        tick();
        tick();

        // Single-cycle pulse then reassert during TURN on the TURN=3 instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req = 4'b0100;
        tick();
        check("pulse_gnt", 32'(gnt3), 32'h4);
        check("pulse_z", 32'(z3), 32'hC2);
        req = '0;
        tick();
        check("pulse_exit_oe", 32'(oe3), 32'h0);
        check("pulse_exit_busy", 32'(busy3), 32'h1);
        req = 4'b0100;
        olow = 0;
        while (!oe3 && olow < 10) begin
            olow++;
            tick();
        end
        check("pulse_oe_low_cycles", 32'(olow), 32'd4);
        check("pulse_regrant", 32'(gnt3), 32'h4);
        req = '0;
        repeat (6) tick();

        // Random request/data run with invariants checked every cycle
        mon_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din = 32'($urandom);
            tick();
        end
        mon_en = 1'b0;
        req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
